dct_block_arbiter: RTL and testbench
====================================

# dct_block_arbiter

Round-robin scheduler that shares one whole-block 8×8 2-D DCT core among `N_REQ` block producers, for example the Y, Cb and Cr tile streams. It grants one requester at a time and forwards that requester's 64-sample block to the core. It holds the grant until the core's 64-coefficient result has been handed downstream, then tags the result with the owner's ID. Only one block is in flight at a time, which matches the core's non-overlapped block processing.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesters, 2..4.
- `IN_W`, default 32: sample/coefficient width; must equal the core's `IN_W`.
- `ID_W`, default 2: requester ID width; must satisfy 2**`ID_W` ≥ `N_REQ`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `req_valid`  in  `N_REQ`  per-requester block valid.
- `req_block`  in  `N_REQ`*64*`IN_W`  requester r occupies slice [r*64*`IN_W` +: 64*`IN_W`]; row-major, sample 0 in the LSBs.
- `req_ready`  out  `N_REQ`  per-requester accept.
- `core_in_valid`  out  1  block valid to the DCT core.
- `core_in_block`  out  64*`IN_W`  block to the core.
- `core_in_ready`  in  1  core accepts a block.
- `core_out_valid`  in  1  core result valid.
- `core_out_block`  in  64*`IN_W`  core coefficients.
- `core_out_ready`  out  1  back-pressure to the core.
- `out_valid`  out  1  tagged result valid.
- `out_block`  out  64*`IN_W`  coefficients.
- `out_id`  out  `ID_W`  owning requester index.
- `out_ready`  in  1  downstream accept.
- `busy`  out  1  high whenever state ≠ S_IDLE.

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT. Registers: `state`, `grant` (`ID_W` bits), `last` (`ID_W` bits).
- S_IDLE:
  - If any `req_valid` is set, select the first requester set in `req_valid`, searching from (`last`+1) mod `N_REQ` upward with wrap.
  - Register the selection in `grant` and go to S_ISSUE.
  - All `req_ready` = 0.
- S_ISSUE:
  - `core_in_valid` = `req_valid[grant]`; `core_in_block` = slice `grant` of `req_block`.
  - `req_ready[grant]` = `core_in_ready`; all other `req_ready` = 0.
  - On `core_in_valid && core_in_ready`, go to S_WAIT.
- S_WAIT:
  - `out_valid` = `core_out_valid`; `out_block` = `core_out_block`; `out_id` = `grant`; `core_out_ready` = `out_ready`.
  - On `core_out_valid && out_ready`: set `last` ← `grant` and go to S_IDLE.
- Outside S_WAIT: `out_valid` = 0, `core_out_ready` = 0, `out_block` = 0, `out_id` = `grant`.
- Outside S_ISSUE: `core_in_valid` = 0, `core_in_block` = 0.
- Data path is pass-through only. No sample storage and no arithmetic.
- Boundary conditions:
  - Granted requester drops `req_valid` in S_ISSUE (protocol violation): `core_in_valid` follows it low, the grant is held, and there is no re-arbitration.
  - `core_out_valid` high outside S_WAIT: ignored, with `core_out_ready` = 0.
  - New `req_valid` arriving in S_ISSUE or S_WAIT: waits for the next S_IDLE.
  - Single active requester: it is re-granted every S_IDLE visit.

## Timing
- Reset values: `state` = S_IDLE, `grant` = 0, `last` = `N_REQ`-1 (so requester 0 wins first). All outputs 0; `out_id` = 0.
- `rst` asserted mid-operation returns to S_IDLE at the next edge. The in-flight block is abandoned, so the core must be reset together with the arbiter.
- Arbitration overhead: 1 cycle. `req_valid` seen in S_IDLE at edge N gives `core_in_valid` in cycle N+1.
- Result path is combinational: `core_out_valid` → `out_valid` in the same cycle, and `out_ready` → `core_out_ready` in the same cycle.
- Back-to-back blocks: S_IDLE is re-entered for 1 cycle after each result handshake. Per-block cost = core turnaround + 1 cycle.

## Configuration
- `DCT_ARB_PERF_EN` defined:
  - Adds output port `perf_cnt`, `N_REQ`*32 bits.
  - Counter r increments on every S_ISSUE handshake where `grant` = r.
  - Counters saturate at 2^32-1 and reset to 0.
- `DCT_ARB_PERF_EN` undefined: `perf_cnt` port and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then `req_valid` = 3'b001 with block = ramp 0..63: `core_in_valid` 1 cycle later; result passed to `out_*` with `out_id` = 0; `busy` low after the `out_ready` handshake.
- `req_valid` = 3'b111 held for 6 blocks: grant order 0,1,2,0,1,2; `out_id` sequence matches.
- `req_valid` = 3'b101 after requester 0 was served: requester 2 is granted next, then 0.
- `out_ready` held low for 20 cycles while the result is valid: `core_out_ready` = 0, `out_valid` stays 1 with a stable block, and no new grant is issued.
- Assert `rst` for 1 cycle while in S_WAIT: all outputs 0 on the next cycle; next request from requester 1 alone is granted.
- With `DCT_ARB_PERF_EN`: traffic of 4 blocks to requester 0 and 2 to requester 1 gives `perf_cnt` slices 4, 2, 0.

Source files
------------

// File: rtl/dct_block_arbiter.sv
// dct_block_arbiter
//   Round-robin scheduler that shares one whole-block 8x8 DCT core among
//   N_REQ block producers. Only one block is in flight at a time. The grant
//   is held from issue until the core's result has been taken downstream,
//   and the result is tagged with the owner's ID.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   req_valid/ready  per-requester handshake; req_block packs N_REQ blocks,
//                    requester r at [r*64*IN_W +: 64*IN_W]
//   core_in_*        block issue to the DCT core
//   core_out_*       coefficient result from the DCT core
//   out_*            tagged result downstream (out_id = owning requester)
//   busy             high whenever the arbiter is not idle
//
// Optional feature (macro DCT_ARB_PERF_EN)
//   Adds perf_cnt (N_REQ x 32 bits): one saturating counter per requester,
//   counting accepted block issues.
module dct_block_arbiter #(
    parameter int N_REQ = 3,
    parameter int IN_W  = 32,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*64*IN_W-1:0] req_block,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     core_in_valid,
    output logic [64*IN_W-1:0]       core_in_block,
    input  logic                     core_in_ready,
    input  logic                     core_out_valid,
    input  logic [64*IN_W-1:0]       core_out_block,
    output logic                     core_out_ready,
    output logic                     out_valid,
    output logic [64*IN_W-1:0]       out_block,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready,
`ifdef DCT_ARB_PERF_EN
    output logic [N_REQ*32-1:0]      perf_cnt,
`endif
    output logic                     busy
);

    localparam int BW = 64 * IN_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_q,  last_d;

    // Unpacked view of the requester blocks so the mux indexes by grant.
    logic [BW-1:0] blk [N_REQ];
    for (genvar r = 0; r < N_REQ; r++) begin : g_blk
        assign blk[r] = req_block[r*BW +: BW];
    end

    // Round-robin pick: first set request starting just after the last
    // requester served, wrapping modulo N_REQ.
    logic [ID_W-1:0] pick, cand;
    logic            pick_vld;
    always_comb begin
        pick     = grant_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % N_REQ);
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    logic issue_hs, result_hs;
    assign issue_hs  = (state_q == S_ISSUE) && req_valid[grant_q] && core_in_ready;
    assign result_hs = (state_q == S_WAIT) && core_out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        req_ready      = '0;
        core_in_valid  = 1'b0;
        core_in_block  = '0;
        core_out_ready = 1'b0;
        out_valid      = 1'b0;
        out_block      = '0;
        out_id         = grant_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A granted requester that drops valid keeps the grant; no
                // re-arbitration until the block is actually accepted.
                core_in_valid      = req_valid[grant_q];
                core_in_block      = blk[grant_q];
                req_ready[grant_q] = core_in_ready;
                if (issue_hs) state_d = S_WAIT;
            end
            S_WAIT: begin
                out_valid      = core_out_valid;
                out_block      = core_out_block;
                core_out_ready = out_ready;
                if (result_hs) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign busy = (state_q != S_IDLE);

`ifdef DCT_ARB_PERF_EN
    logic [31:0] perf_q [N_REQ];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N_REQ; r++) perf_q[r] <= '0;
        end else if (issue_hs && perf_q[grant_q] != '1) begin
            perf_q[grant_q] <= perf_q[grant_q] + 32'd1;
        end
    end
    for (genvar r = 0; r < N_REQ; r++) begin : g_perf
        assign perf_cnt[r*32 +: 32] = perf_q[r];
    end
`endif

endmodule

// File: tb/tb_dct_block_arbiter.sv
module tb_dct_block_arbiter;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int BW = 64 * W;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*BW-1:0]   req_block;
    logic [N-1:0]      req_ready;
    logic              core_in_valid;
    logic [BW-1:0]     core_in_block;
    logic              core_in_ready;
    logic              core_out_valid;
    logic [BW-1:0]     core_out_block;
    logic              core_out_ready;
    logic              out_valid;
    logic [BW-1:0]     out_block;
    logic [IW-1:0]     out_id;
    logic              out_ready;
    logic              busy;
`ifdef DCT_ARB_PERF_EN
    logic [N*32-1:0]   perf_cnt;
`endif

    dct_block_arbiter #(.N_REQ(N), .IN_W(W), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_block(req_block), .req_ready(req_ready),
        .core_in_valid(core_in_valid), .core_in_block(core_in_block),
        .core_in_ready(core_in_ready),
        .core_out_valid(core_out_valid), .core_out_block(core_out_block),
        .core_out_ready(core_out_ready),
        .out_valid(out_valid), .out_block(out_block), .out_id(out_id),
        .out_ready(out_ready),
`ifdef DCT_ARB_PERF_EN
        .perf_cnt(perf_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state: who was served last, per-requester issue counts,
    // and the block each requester is currently presenting.
    int            last_m;
    int            perf_m [N];
    logic [BW-1:0] blk_m [N];

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            int r;
            r = (last + k) % N;
            if (m[r]) return r;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_blocks(input bit ramp);
        for (int r = 0; r < N; r++) begin
            for (int w = 0; w < 64; w++)
                blk_m[r][w*W +: W] = ramp ? W'(w) : W'($urandom);
            req_block[r*BW +: BW] = blk_m[r];
        end
    endtask

    task automatic model_reset();
        last_m = N - 1;
        for (int r = 0; r < N; r++) perf_m[r] = 0;
    endtask

    // One full block transaction starting from idle.
    task automatic run_block(input logic [N-1:0] m, input int stall, input int lat,
                             input int hold, input bit drop);
        int            g;
        logic [BW-1:0] res;
        g = rr_pick(m, last_m);
        req_valid     = m;
        core_in_ready = 1'b0;
        step();
        chk("iss_busy", 64'(busy), 64'd1);
        chk("iss_civ", 64'(core_in_valid), 64'd1);
        chk("iss_blk", 64'(core_in_block == blk_m[g]), 64'd1);
        chk("iss_rdy0", 64'(req_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            core_out_valid = 1'b1;            // stray result outside WAIT
            #1;
            chk("stray_cor", 64'(core_out_ready), 64'd0);
            chk("stray_ov", 64'(out_valid), 64'd0);
            chk("stray_ob", 64'(out_block == '0), 64'd1);
            step();
        end
        core_out_valid = 1'b0;
        if (drop) begin
            req_valid[g]  = 1'b0;
            core_in_ready = 1'b1;
            #1;
            chk("drop_civ", 64'(core_in_valid), 64'd0);
            step();
            chk("drop_busy", 64'(busy), 64'd1);
            chk("drop_rdy", 64'(req_ready), 64'(1 << g));
            chk("drop_blk", 64'(core_in_block == blk_m[g]), 64'd1);
            req_valid = m;
        end
        core_in_ready = 1'b1;
        #1;
        chk("iss_rdy", 64'(req_ready), 64'(1 << g));
        perf_m[g]++;
        step();
        core_in_ready = 1'b0;
        req_valid     = N'($urandom);         // late arrivals must wait
        #1;
        chk("wait_civ", 64'(core_in_valid), 64'd0);
        chk("wait_rdy", 64'(req_ready), 64'd0);
        for (int i = 0; i < lat; i++) begin
            chk("lat_ov", 64'(out_valid), 64'd0);
            step();
        end
        res = '0;
        for (int w = 0; w < 64; w++) res[w*W +: W] = W'($urandom);
        core_out_valid = 1'b1;
        core_out_block = res;
        out_ready      = 1'b0;
        #1;
        for (int i = 0; i < hold; i++) begin
            chk("hold_ov", 64'(out_valid), 64'd1);
            chk("hold_ob", 64'(out_block == res), 64'd1);
            chk("hold_id", 64'(out_id), 64'(g));
            chk("hold_cor", 64'(core_out_ready), 64'd0);
            chk("hold_civ", 64'(core_in_valid), 64'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("res_ov", 64'(out_valid), 64'd1);
        chk("res_ob", 64'(out_block == res), 64'd1);
        chk("res_id", 64'(out_id), 64'(g));
        chk("res_cor", 64'(core_out_ready), 64'd1);
        step();
        core_out_valid = 1'b0;
        out_ready      = 1'b0;
        req_valid      = '0;
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ov", 64'(out_valid), 64'd0);
        last_m = g;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_block = '0; core_in_ready = 1'b0;
        core_out_valid = 1'b0; core_out_block = '0; out_ready = 1'b0;
        model_reset();
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_civ", 64'(core_in_valid), 64'd0);
        chk("rst_cib", 64'(core_in_block == '0), 64'd1);
        chk("rst_rdy", 64'(req_ready), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);
        chk("rst_cor", 64'(core_out_ready), 64'd0);

        // Ramp block from requester 0 alone.
        set_blocks(1'b1);
        run_block(3'b001, 0, 3, 0, 1'b0);
        // All three requesting for 6 blocks: rotates through everyone.
        set_blocks(1'b0);
        for (int i = 0; i < 6; i++) run_block(3'b111, 0, 1, 0, 1'b0);
        // Requester 0 served, then 0 and 2 contend: 2 then 0.
        run_block(3'b001, 0, 0, 0, 1'b0);
        run_block(3'b101, 0, 0, 0, 1'b0);
        run_block(3'b101, 0, 0, 0, 1'b0);
        // Long downstream stall, stray core result, dropped request.
        run_block(3'b111, 2, 2, 20, 1'b0);
        run_block(3'b110, 0, 0, 1, 1'b1);
        // Single requester is re-granted every time.
        run_block(3'b010, 0, 0, 0, 1'b0);
        run_block(3'b010, 0, 0, 0, 1'b0);

        // Reset while waiting on the core result.
        set_blocks(1'b0);
        req_valid     = 3'b001;
        core_in_ready = 1'b1;
        step(); step();
        core_out_valid = 1'b1;
        core_out_block = BW'($urandom);
        req_valid      = '0;
        #1;
        chk("pre_rst_ov", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_cor", 64'(core_out_ready), 64'd0);
        chk("mid_rst_civ", 64'(core_in_valid), 64'd0);
        chk("mid_rst_ob", 64'(out_block == '0), 64'd1);
        chk("mid_rst_id", 64'(out_id), 64'd0);
        rst = 1'b0; core_out_valid = 1'b0; core_in_ready = 1'b0;
        model_reset();
        run_block(3'b010, 0, 1, 0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            set_blocks(1'b0);
            run_block(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2),
                      $urandom_range(0, 4), $urandom_range(0, 3),
                      $urandom_range(0, 3) == 0);
        end

`ifdef DCT_ARB_PERF_EN
        // Fresh counters: 4 blocks to requester 0, 2 to requester 1.
        rst = 1'b1; step(); rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) run_block(3'b001, 0, 1, 0, 1'b0);
        for (int i = 0; i < 2; i++) run_block(3'b010, 0, 1, 0, 1'b0);
        for (int r = 0; r < N; r++)
            chk("perf", 64'(perf_cnt[r*32 +: 32]), 64'(perf_m[r]));
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
